// File: rtl/muldiv_unit_e.sv
// Iterative RV32M multiply/divide unit for the Execute stage: 32-cycle shift-add
// multiply or restoring divide, busy stall while working, one-cycle done pulse.
module muldiv_unit_e #(
  parameter int DATA_WIDTH   = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [4:0]            rd_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [4:0]            rd_o,
  output logic [1:0]            dbg_state_o
);
  localparam int W = DATA_WIDTH;

  // Handshake: start_i is accepted only in IDLE without flush_i; done_o is a
  // single-cycle valid for result_o/rd_o, which then hold until the next done.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [2:0]     r_op;
  logic [4:0]     r_rd;
  logic [W-1:0]   r_opnd;
  logic [2*W-1:0] r_acc;
  logic           r_neg_q;
  logic           r_neg_r;
  logic [4:0]     r_count;
  logic [W-1:0]   r_result;
  logic [4:0]     r_rd_out;

  logic           w_a_signed;
  logic           w_b_signed;
  logic           w_a_neg;
  logic           w_b_neg;
  logic [W-1:0]   w_a_mag;
  logic [W-1:0]   w_b_mag;
  logic           w_b_zero;
  logic           w_ovf;
  logic           w_special;
  logic [W-1:0]   w_special_res;
  logic           w_accept;
  logic           w_last;
  logic [W:0]     w_add;
  logic [W:0]     w_sh;
  logic [W:0]     w_sub;
  logic [2*W-1:0] w_acc_next;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quot;
  logic [W-1:0]   w_rem;
  logic [W-1:0]   w_calc_res;

  assign w_a_signed = (op_i == 3'b001) | (op_i == 3'b010) | (op_i == 3'b100) | (op_i == 3'b110);
  assign w_b_signed = (op_i == 3'b001) | (op_i == 3'b100) | (op_i == 3'b110);
  assign w_a_neg    = w_a_signed & a_i[W-1];
  assign w_b_neg    = w_b_signed & b_i[W-1];
  assign w_a_mag    = w_a_neg ? -a_i : a_i;
  assign w_b_mag    = w_b_neg ? -b_i : b_i;
  assign w_b_zero   = (b_i == {W{1'b0}});
  assign w_ovf      = op_i[2] & ~op_i[0] & (a_i == {1'b1, {(W-1){1'b0}}}) & (b_i == {W{1'b1}});
  assign w_special  = op_i[2] & (w_b_zero | w_ovf);
  assign w_special_res = op_i[1] ? (w_b_zero ? a_i : {W{1'b0}})
                                 : (w_b_zero ? {W{1'b1}} : a_i);
  assign w_accept   = (r_state == S_IDLE) & start_i & ~flush_i;
  assign w_last     = (r_count == 5'(W-1));

  // Multiply keeps {partial_hi, multiplier} in r_acc and shifts right;
  // divide keeps {remainder, dividend/quotient} and shifts left.
  assign w_add = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
  assign w_sh  = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_sub = w_sh - {1'b0, r_opnd};

  always_comb begin
    w_acc_next = {w_add, r_acc[W-1:1]};
    if (r_op[2]) begin
      if (w_sub[W]) w_acc_next = {w_sh[W-1:0], r_acc[W-2:0], 1'b0};
      else          w_acc_next = {w_sub[W-1:0], r_acc[W-2:0], 1'b1};
    end
  end

  assign w_prod = r_neg_q ? -w_acc_next : w_acc_next;
  assign w_quot = r_neg_q ? -w_acc_next[W-1:0] : w_acc_next[W-1:0];
  assign w_rem  = r_neg_r ? -w_acc_next[2*W-1:W] : w_acc_next[2*W-1:W];

  always_comb begin
    w_calc_res = w_rem;
    case (r_op)
      3'b000:                 w_calc_res = w_prod[W-1:0];
      3'b001, 3'b010, 3'b011: w_calc_res = w_prod[2*W-1:W];
      3'b100, 3'b101:         w_calc_res = w_quot;
      default:                w_calc_res = w_rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = (FAST_SPECIAL && w_special) ? S_DONE : S_CALC;
      S_CALC: begin
        if (flush_i)     w_state_next = S_IDLE;
        else if (w_last) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= 3'd0;
      r_rd     <= 5'd0;
      r_opnd   <= {W{1'b0}};
      r_acc    <= {(2*W){1'b0}};
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_count  <= 5'd0;
      r_result <= {W{1'b0}};
      r_rd_out <= 5'd0;
    end else if (w_accept) begin
      r_op    <= op_i;
      r_rd    <= rd_i;
      r_opnd  <= op_i[2] ? w_b_mag : w_a_mag;
      r_acc   <= {{W{1'b0}}, (op_i[2] ? w_a_mag : w_b_mag)};
      // A zero divisor must leave the all-ones quotient magnitude unsigned.
      r_neg_q <= (w_a_neg ^ w_b_neg) & ~w_b_zero;
      r_neg_r <= w_a_neg;
      r_count <= 5'd0;
      if (FAST_SPECIAL && w_special) begin
        r_result <= w_special_res;
        r_rd_out <= rd_i;
      end
    end else if (r_state == S_CALC && !flush_i) begin
      r_acc   <= w_acc_next;
      r_count <= r_count + 5'd1;
      if (w_last) begin
        r_result <= w_calc_res;
        r_rd_out <= r_rd;
      end
    end
  end

  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign result_o    = r_result;
  assign rd_o        = r_rd_out;
  assign dbg_state_o = r_state;
endmodule
